// File: rtl/hack_mem_bus.sv
// Hack data-memory subsystem: RAM, screen shadow, keyboard register and a
// screen-write FIFO that hands pixel words to the video writer.
module hack_mem_bus #(
    parameter int FIFO_DEPTH = 8,
    parameter int RAM_WORDS  = 16384,
    parameter int SCR_WORDS  = 8192
) (
    input  logic        CLK_100MHz,
    input  logic        reset,
    input  logic        cpu_strobe,
    input  logic [15:0] addressM,
    input  logic [15:0] outM,
    input  logic        loadM,
    output logic [15:0] inM,
    output logic [12:0] scr_addr,
    output logic [15:0] scr_data,
    output logic        scr_valid,
    input  logic        scr_ready,
    input  logic        kbd_valid,
    input  logic [15:0] kbd_code,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int SCR_AW = $clog2(SCR_WORDS);

    logic [15:0] r_ram [RAM_WORDS];
    logic [15:0] r_scr [SCR_WORDS];

    logic [12:0] r_fifo_addr [FIFO_DEPTH];
    logic [15:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic [15:0] r_kbd;
    logic [15:0] r_inM;
    logic        r_overflow;

    logic        w_is_ram;
    logic        w_is_scr;
    logic        w_is_kbd;
    logic        w_wr;
    logic        w_wr_ram;
    logic        w_wr_scr;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_push_ok;
    logic        w_drop;
    logic [15:0] w_rd_data;

    // Address decode
    always_comb begin
        w_is_ram = (addressM[15:14] == 2'b00);
        w_is_scr = (addressM[15:13] == 3'b010);
        w_is_kbd = (addressM == 16'h6000);
    end

    always_comb begin
        w_wr      = cpu_strobe && loadM;
        w_wr_ram  = w_wr && w_is_ram;
        w_wr_scr  = w_wr && w_is_scr;
        w_full    = (r_count == CNT_W'(FIFO_DEPTH));
        w_empty   = (r_count == '0);
        w_pop     = !w_empty && scr_ready;
        // A full FIFO still accepts a push when the head leaves on the same edge.
        w_push_ok = w_wr_scr && (!w_full || w_pop);
        w_drop    = w_wr_scr && w_full && !w_pop;
    end

    always_comb begin
        w_rd_data = 16'h0000;
        if (w_is_ram) begin
            w_rd_data = r_ram[addressM[RAM_AW-1:0]];
        end else if (w_is_scr) begin
            w_rd_data = r_scr[addressM[SCR_AW-1:0]];
        end else if (w_is_kbd) begin
            w_rd_data = r_kbd;
        end
    end

    // Storage arrays carry no reset
    always_ff @(posedge CLK_100MHz) begin
        if (w_wr_ram) begin
            r_ram[addressM[RAM_AW-1:0]] <= outM;
        end
        if (w_wr_scr) begin
            r_scr[addressM[SCR_AW-1:0]] <= outM;
        end
        if (w_push_ok) begin
            r_fifo_addr[r_wptr] <= addressM[12:0];
            r_fifo_data[r_wptr] <= outM;
        end
    end

    // Read port with write-first forwarding of a same-edge store
    always_ff @(posedge CLK_100MHz or posedge reset) begin
        if (reset) begin
            r_inM <= 16'h0000;
        end else if (w_wr_ram || w_wr_scr) begin
            r_inM <= outM;
        end else begin
            r_inM <= w_rd_data;
        end
    end

    always_ff @(posedge CLK_100MHz or posedge reset) begin
        if (reset) begin
            r_kbd <= 16'h0000;
        end else if (kbd_valid) begin
            r_kbd <= kbd_code;
        end
    end

    always_ff @(posedge CLK_100MHz or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge CLK_100MHz or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK_100MHz or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Flags are combinational from count so an async reset clears them at once
    always_comb begin
        inM       = r_inM;
        scr_addr  = r_fifo_addr[r_rptr];
        scr_data  = r_fifo_data[r_rptr];
        scr_valid = !w_empty;
        fifo_full = w_full;
        overflow  = r_overflow;
    end

endmodule

// File: tb/tb_hack_mem_bus.sv
// Directed bench for hack_mem_bus: memory map, screen FIFO, keyboard, reset.
module tb_hack_mem_bus;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_strobe;
    logic [15:0] addressM;
    logic [15:0] outM;
    logic        loadM;
    logic [15:0] inM;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;
    logic        scr_valid;
    logic        scr_ready;
    logic        kbd_valid;
    logic [15:0] kbd_code;
    logic        fifo_full;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    hack_mem_bus #(.FIFO_DEPTH(8), .RAM_WORDS(16384), .SCR_WORDS(8192)) dut (
        .CLK_100MHz(clk),
        .reset(reset),
        .cpu_strobe(cpu_strobe),
        .addressM(addressM),
        .outM(outM),
        .loadM(loadM),
        .inM(inM),
        .scr_addr(scr_addr),
        .scr_data(scr_data),
        .scr_valid(scr_valid),
        .scr_ready(scr_ready),
        .kbd_valid(kbd_valid),
        .kbd_code(kbd_code),
        .fifo_full(fifo_full),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        addressM   = a;
        outM       = d;
        loadM      = 1'b1;
        cpu_strobe = 1'b1;
        tick();
        cpu_strobe = 1'b0;
        loadM      = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        addressM = a;
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        cpu_strobe = 1'b0;
        addressM   = 16'h0000;
        outM       = 16'h0000;
        loadM      = 1'b0;
        scr_ready  = 1'b0;
        kbd_valid  = 1'b0;
        kbd_code   = 16'h0000;
        tick();
        tick();
        check("rst_inM", inM, 0);
        check("rst_valid", scr_valid, 0);
        check("rst_full", fifo_full, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b0;
        tick();

        // RAM round trip
        wr(16'h0010, 16'h1234);
        tick();
        check("ram_rt", inM, 16'h1234);
        check("ram_no_push", scr_valid, 0);
        rd(16'h0011);

        // Screen path with back-pressure
        wr(16'h4000, 16'hAAAA);
        wr(16'h5FFF, 16'h5555);
        check("scr_valid", scr_valid, 1);
        check("scr_head0_a", scr_addr, 13'h0000);
        check("scr_head0_d", scr_data, 16'hAAAA);
        tick();
        check("scr_hold_a", scr_addr, 13'h0000);
        check("scr_hold_d", scr_data, 16'hAAAA);
        scr_ready = 1'b1;
        tick();
        check("scr_head1_a", scr_addr, 13'h1FFF);
        check("scr_head1_d", scr_data, 16'h5555);
        check("scr_head1_v", scr_valid, 1);
        tick();
        check("scr_drained", scr_valid, 0);
        scr_ready = 1'b0;
        rd(16'h5FFF);
        check("scr_shadow", inM, 16'h5555);

        // Fill, overflow, then push+pop while full
        for (int i = 0; i < 8; i++) begin
            wr(16'h4000 + 16'(i), 16'h1000 + 16'(i));
            if (i == 6) check("full_at7", fifo_full, 0);
        end
        check("full_at8", fifo_full, 1);
        check("ovf_at8", overflow, 0);
        wr(16'h4100, 16'hDEAD);
        check("ovf_at9", overflow, 1);
        check("full_at9", fifo_full, 1);
        rd(16'h4100);
        check("ovf_shadow", inM, 16'hDEAD);
        scr_ready = 1'b1;
        wr(16'h4200, 16'hBEEF);
        check("pp_full", fifo_full, 1);
        check("pp_ovf", overflow, 1);
        for (int i = 1; i < 8; i++) begin
            check("drain_a", scr_addr, 32'(i));
            check("drain_d", scr_data, 32'h1000 + 32'(i));
            tick();
            if (i == 1) check("drain_notfull", fifo_full, 0);
        end
        check("drain_last_a", scr_addr, 13'h0200);
        check("drain_last_d", scr_data, 16'hBEEF);
        tick();
        check("drain_empty", scr_valid, 0);
        tick();
        check("ready_empty", scr_valid, 0);
        scr_ready = 1'b0;

        // Keyboard
        addressM  = 16'h6000;
        kbd_code  = 16'h0041;
        kbd_valid = 1'b1;
        tick();
        kbd_valid = 1'b0;
        kbd_code  = 16'h0000;
        tick();
        check("kbd_load", inM, 16'h0041);
        wr(16'h6000, 16'hFFFF);
        tick();
        check("kbd_ro", inM, 16'h0041);
        check("kbd_no_push", scr_valid, 0);
        kbd_valid = 1'b1;
        tick();
        kbd_valid = 1'b0;
        tick();
        check("kbd_release", inM, 16'h0000);

        // Unmapped address, checked against the aliased RAM/SCR words
        wr(16'h3000, 16'h1111);
        scr_ready = 1'b1;
        wr(16'h5000, 16'h2222);
        check("empty_pp_valid", scr_valid, 1);
        check("empty_pp_d", scr_data, 16'h2222);
        tick();
        check("empty_pp_pop", scr_valid, 0);
        scr_ready = 1'b0;
        wr(16'h7000, 16'h9999);
        check("unm_no_push", scr_valid, 0);
        tick();
        check("unm_read", inM, 16'h0000);
        rd(16'h3000);
        check("unm_ram", inM, 16'h1111);
        rd(16'h5000);
        check("unm_scr", inM, 16'h2222);

        // Pointer wrap with one-deep streaming
        scr_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr(16'h4000 + 16'(i * 3), 16'hC000 + 16'(i));
            check("wrap_a", scr_addr, 32'(i * 3));
            check("wrap_d", scr_data, 32'hC000 + 32'(i));
        end
        tick();
        check("wrap_empty", scr_valid, 0);
        scr_ready = 1'b0;

        // Async reset mid-operation
        wr(16'h4001, 16'h0001);
        wr(16'h4002, 16'h0002);
        wr(16'h4003, 16'h0003);
        check("pre_rst_valid", scr_valid, 1);
        check("pre_rst_ovf", overflow, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", scr_valid, 0);
        check("arst_full", fifo_full, 0);
        check("arst_ovf", overflow, 0);
        check("arst_inM", inM, 0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_valid", scr_valid, 0);
        wr(16'h0000, 16'h0ABC);
        tick();
        check("post_rst_wr", inM, 16'h0ABC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
